fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Program-counter and IF/ID pipeline stage sitting directly upstream of instruction_memory.
//   - Drives the word address (imem_pc) into the combinational instruction memory.
//   - Registers the returned 16-bit instruction, with its PC, into the IF/ID latch for the decoder.
//   - Handles stalls, redirects from execute (jumps/branches), HALT detection and out-of-range fetch faults.
// PARAMETERS
//   RESET_PC    16'h0000  PC value loaded on reset
//   IMEM_DEPTH  256       number of valid instruction words; pc >= IMEM_DEPTH is out of range
//   HALT_INSTR  16'hF800  encoding that stops fetch (matches the memory fill word)
// PORTS
//   clk             in   1   rising-edge clock
//   rst_n           in   1   asynchronous active-low reset
//   imem_pc         out  16  word address to instruction_memory (= pc register)
//   imem_instr      in   16  instruction returned combinationally for imem_pc
//   id_stall        in   1   decode cannot accept; hold PC and IF/ID
//   redirect_valid  in   1   execute requests a PC change (jump/branch taken)
//   redirect_pc     in   16  target word address for the redirect
//   if_id_valid     out  1   IF/ID holds a real instruction
//   if_id_instr     out  16  latched instruction
//   if_id_pc        out  16  address of the latched instruction
//   if_id_pc_plus1  out  16  if_id_pc + 1 (link value for jal)
//   halted          out  1   high while in HALT state
//   fetch_fault     out  1   sticky; PC went out of range
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     pc=RESET_PC; if_id_valid=0; if_id_instr/pc/pc_plus1=0; halted=0; fetch_fault=0; state=RUN.
//   - Word addressing: sequential next PC is pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
//   - States and transitions (priority top-down, evaluated every clk edge):
//     1. redirect_valid=1 (any state except FAULT, even with id_stall=1):
//        pc<=redirect_pc; if_id_valid<=0; state<=RUN. Redirect wins over stall and HALT.
//     2. id_stall=1: pc, IF/ID and state all hold.
//     3. RUN, pc>=IMEM_DEPTH: if_id_valid<=0; pc holds; fetch_fault<=1; state<=FAULT.
//     4. RUN, imem_instr==HALT_INSTR:
//        IF/ID loads the instruction (valid=1) so decode sees HALT; pc holds; state<=HALT.
//     5. RUN, otherwise:
//        if_id_instr<=imem_instr; if_id_pc<=pc; if_id_pc_plus1<=pc+1; if_id_valid<=1; pc<=next_pc.
//     6. HALT: if_id_valid<=0; pc holds; halted=1. Exited only by a redirect or by reset.
//     7. FAULT: terminal until reset; redirect is ignored; if_id_valid<=0.
//   - Latency: an instruction at address A appears on IF/ID one edge after pc==A with no stall.
//   - A redirect costs one bubble (if_id_valid=0 for one cycle).
//   - halted is the registered state (1 in HALT); fetch_fault is registered and sticky.
// CONFIGURATION
//   JAL_PREDECODE_EN
//   - Defined: in RUN with no stall and no redirect, imem_instr[15:11]==5'b00101 (jal) gives
//     next_pc={5'b0, imem_instr[10:0]}. The jal itself still enters IF/ID normally.
//     Execute must not also redirect for jal.
//   - Undefined: next_pc is always pc+1; jal is resolved by execute through redirect_valid.
// TESTING
//   1. Reset, then memory of 10 ALU ops:
//      -> IF/ID shows pc 0..9 on consecutive cycles; if_id_valid=1 from the 1st edge after reset.
//   2. id_stall=1 for 3 cycles at pc=4:
//      -> imem_pc stays 4 and IF/ID stays at pc 3 for 3 cycles; resumes with pc 4.
//   3. redirect_valid=1, redirect_pc=9, applied together with id_stall=1:
//      -> next cycle imem_pc=9 and if_id_valid=0; following cycle IF/ID pc=9.
//   4. HALT_INSTR at address 10:
//      -> IF/ID valid for pc 10; then halted=1, imem_pc stuck at 10, if_id_valid=0.
//      -> redirect to 0 resumes fetch from 0.
//   5. Redirect to 16'h00FF with IMEM_DEPTH=256:
//      -> fetch at 255 succeeds; pc becomes 256; fetch_fault=1, if_id_valid=0.
//      -> a later redirect is ignored; rst_n low clears fault.
//   6. JAL_PREDECODE_EN defined, 16'b0010100000001001 at address 7:
//      -> imem_pc sequence 7, 9 (no 8); IF/ID pc 7 has pc_plus1=8.
//      -> Without the macro the sequence is 7, 8.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register and IF/ID latch in front of the combinational instruction memory
// Optional feature: define JAL_PREDECODE_EN to redirect fetch on jal at fetch time.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [15:0] HALT_INSTR = 16'hF800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus1,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic        valid_n;
    logic [15:0] instr_n, ipc_n, ipc1_n;
    logic        fault_n;
    logic [15:0] pc_inc;
    logic [15:0] seq_pc;
    logic        in_range;

    assign pc_inc   = pc + 16'd1;
    assign in_range = ({16'd0, pc} < IMEM_DEPTH);

`ifdef JAL_PREDECODE_EN
    // jal (opcode 00101) is resolved here; execute must not redirect for it
    assign seq_pc = (imem_instr[15:11] == 5'b00101) ? {5'b0, imem_instr[10:0]} : pc_inc;
`else
    assign seq_pc = pc_inc;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = if_id_valid;
        instr_n = if_id_instr;
        ipc_n   = if_id_pc;
        ipc1_n  = if_id_pc_plus1;
        fault_n = fetch_fault;
        if (state == S_FAULT) begin
            valid_n = 1'b0;
        end else if (redirect_valid) begin
            pc_n    = redirect_pc;
            valid_n = 1'b0;
            state_n = S_RUN;
        end else if (!id_stall) begin
            case (state)
                S_RUN: begin
                    if (!in_range) begin
                        valid_n = 1'b0;
                        fault_n = 1'b1;
                        state_n = S_FAULT;
                    end else begin
                        instr_n = imem_instr;
                        ipc_n   = pc;
                        ipc1_n  = pc_inc;
                        valid_n = 1'b1;
                        // HALT enters IF/ID so decode sees it, but the PC parks on it
                        if (imem_instr == HALT_INSTR) begin
                            state_n = S_HALT;
                        end else begin
                            pc_n = seq_pc;
                        end
                    end
                end
                S_HALT: begin
                    valid_n = 1'b0;
                end
                default: begin
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RUN;
            pc             <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_instr    <= 16'd0;
            if_id_pc       <= 16'd0;
            if_id_pc_plus1 <= 16'd0;
            fetch_fault    <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            if_id_valid    <= valid_n;
            if_id_instr    <= instr_n;
            if_id_pc       <= ipc_n;
            if_id_pc_plus1 <= ipc1_n;
            fetch_fault    <= fault_n;
        end
    end

    assign imem_pc = pc;
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        id_stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        halted;
    logic        fetch_fault;

    logic [15:0] mem [0:255];
    int n_checks;
    int n_fail;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (imem_pc < 16'd256) imem_instr = mem[imem_pc[7:0]];
        else                   imem_instr = 16'hF800;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'd0;
        rst_n          = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_pc !== 16'd0 || if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_fault !== 1'b0 ||
            if_id_instr !== 16'd0 || if_id_pc !== 16'd0 || if_id_pc_plus1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: pc=%h v=%b h=%b f=%b instr=%h ipc=%h ipc1=%h required all zero",
                     imem_pc, if_id_valid, halted, fetch_fault, if_id_instr, if_id_pc, if_id_pc_plus1);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 16'(i) || if_id_instr !== 16'(16'h1000 + i) ||
                if_id_pc_plus1 !== 16'(i + 1) || imem_pc !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL seq[%0d]: v=%b pc=%h instr=%h pc1=%h imem_pc=%h required v=1 pc=%h", i,
                         if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus1, imem_pc, 16'(i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) step();
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_pc !== 16'd4 || if_id_pc !== 16'd3 || if_id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall[%0d]: imem_pc=%h ipc=%h v=%b required 0004 0003 1", i,
                         imem_pc, if_id_pc, if_id_valid);
            end
        end
        id_stall = 1'b0;
        step();
        n_checks++;
        if (if_id_pc !== 16'd4 || if_id_valid !== 1'b1 || imem_pc !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_resume: ipc=%h v=%b imem_pc=%h required 0004 1 0005",
                     if_id_pc, if_id_valid, imem_pc);
        end
    endtask

    task automatic test_redirect_halt();
        redirect_valid = 1'b1;
        redirect_pc    = 16'd9;
        id_stall       = 1'b1;
        step();
        n_checks++;
        if (imem_pc !== 16'd9 || if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_bubble: imem_pc=%h v=%b required 0009 0", imem_pc, if_id_valid);
        end
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        step();
        n_checks++;
        if (if_id_pc !== 16'd9 || if_id_valid !== 1'b1 || if_id_instr !== 16'h1009) begin
            n_fail++;
            $display("FAIL redirect_target: ipc=%h v=%b instr=%h required 0009 1 1009",
                     if_id_pc, if_id_valid, if_id_instr);
        end
        step();
        n_checks++;
        if (if_id_pc !== 16'd10 || if_id_valid !== 1'b1 || if_id_instr !== 16'hF800 ||
            halted !== 1'b1 || imem_pc !== 16'd10) begin
            n_fail++;
            $display("FAIL halt_enter: ipc=%h v=%b instr=%h h=%b imem_pc=%h required 000a 1 f800 1 000a",
                     if_id_pc, if_id_valid, if_id_instr, halted, imem_pc);
        end
        repeat (2) begin
            step();
            n_checks++;
            if (if_id_valid !== 1'b0 || halted !== 1'b1 || imem_pc !== 16'd10) begin
                n_fail++;
                $display("FAIL halt_hold: v=%b h=%b imem_pc=%h required 0 1 000a",
                         if_id_valid, halted, imem_pc);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'd0;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_pc !== 16'd0 || halted !== 1'b0 || if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: imem_pc=%h h=%b v=%b required 0000 0 0", imem_pc, halted, if_id_valid);
        end
        step();
        n_checks++;
        if (if_id_pc !== 16'd0 || if_id_valid !== 1'b1 || imem_pc !== 16'd1) begin
            n_fail++;
            $display("FAIL halt_resume: ipc=%h v=%b imem_pc=%h required 0000 1 0001",
                     if_id_pc, if_id_valid, imem_pc);
        end
    endtask

    task automatic test_fault();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h00FF;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (if_id_pc !== 16'h00FF || if_id_valid !== 1'b1 || if_id_instr !== 16'h1234 ||
            imem_pc !== 16'h0100 || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_last_ok: ipc=%h v=%b instr=%h imem_pc=%h f=%b required 00ff 1 1234 0100 0",
                     if_id_pc, if_id_valid, if_id_instr, imem_pc, fetch_fault);
        end
        step();
        n_checks++;
        if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || imem_pc !== 16'h0100) begin
            n_fail++;
            $display("FAIL fault_set: f=%b v=%b imem_pc=%h required 1 0 0100", fetch_fault, if_id_valid, imem_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'd0;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || imem_pc !== 16'h0100) begin
            n_fail++;
            $display("FAIL fault_sticky: f=%b v=%b imem_pc=%h required 1 0 0100", fetch_fault, if_id_valid, imem_pc);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fetch_fault !== 1'b0 || imem_pc !== 16'd0) begin
            n_fail++;
            $display("FAIL fault_clear: f=%b imem_pc=%h required 0 0000", fetch_fault, imem_pc);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_jal();
        logic [15:0] exp_next;
`ifdef JAL_PREDECODE_EN
        exp_next = 16'd9;
`else
        exp_next = 16'd8;
`endif
        mem[7] = 16'b0010100000001001;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'd7;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_pc !== 16'd7) begin
            n_fail++;
            $display("FAIL jal_start: imem_pc=%h required 0007", imem_pc);
        end
        step();
        n_checks++;
        if (if_id_pc !== 16'd7 || if_id_pc_plus1 !== 16'd8 || if_id_instr !== 16'h2809 ||
            if_id_valid !== 1'b1 || imem_pc !== exp_next) begin
            n_fail++;
            $display("FAIL jal_next: ipc=%h pc1=%h instr=%h v=%b imem_pc=%h required 0007 0008 2809 1 %h",
                     if_id_pc, if_id_pc_plus1, if_id_instr, if_id_valid, imem_pc, exp_next);
        end
        mem[7] = 16'h1007;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF800;
        for (int i = 0; i < 10; i++) mem[i] = 16'(16'h1000 + i);
        mem[255]       = 16'h1234;
        rst_n          = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'd0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_halt();
        test_fault();
        test_jal();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
